// File: rtl/esc_ping_pkg.sv
// Shared types and constants for the escalation ping scheduler.
// Holds the FSM state enum and the jitter LFSR constants.
package esc_ping_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PING
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam int          JitW     = 4;

endpackage

// File: rtl/esc_ping_lfsr.sv
// Free-running 16-bit Galois LFSR supplying ping wait jitter.
// Only instantiated when ESC_PING_JITTER_EN is defined.
module esc_ping_lfsr
  import esc_ping_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [JitW-1:0] jit_o
);

  logic [15:0] lfsr_q;

  // Advance one step every cycle from the fixed seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'h0);
    end
  end

  assign jit_o = lfsr_q[JitW-1:0];

endmodule

// File: rtl/esc_ping_scheduler.sv
// Round-robin periodic ping scheduler for escalation senders.
// Define ESC_PING_JITTER_EN to add 0..15 cycles of LFSR wait jitter.
module esc_ping_scheduler
  import esc_ping_pkg::*;
#(
  parameter  int NumEsc = 4,
  parameter  int CntW   = 24,
  localparam int SelW   = $clog2(NumEsc)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NumEsc-1:0] en_mask_i,
  input  logic [NumEsc-1:0] esc_active_i,
  input  logic [CntW-1:0]   wait_cyc_i,
  input  logic [CntW-1:0]   timeout_cyc_i,
  input  logic [NumEsc-1:0] ping_ok_i,
  output logic [NumEsc-1:0] ping_en_o,
  output logic [NumEsc-1:0] ping_fail_o,
  output logic [SelW-1:0]   ping_sel_o,
  output logic              busy_o
);

  state_e              state_q, state_d;
  logic [CntW:0]       wcnt_q;
  logic [CntW-1:0]     tcnt_q;
  logic [SelW-1:0]     ptr_q, sel_q;
  logic [NumEsc-1:0]   fail_q, fail_d;
  logic [NumEsc-1:0]   sel_oh;
  logic                load_wait, load_to, take;
  logic                pick_vld;
  logic [SelW-1:0]     pick_idx;
  logic [CntW-1:0]     w_eff, t_eff;
  logic [CntW:0]       wait_load;
  logic [JitW-1:0]     jit;

  // Nearest eligible channel after ptr, wrapping; msb flags a hit.
  function automatic logic [SelW:0] rr_pick(
    input logic [NumEsc-1:0] elig,
    input logic [SelW-1:0]   ptr
  );
    logic [SelW:0] res;
    int            idx;
    res = '0;
    for (int i = NumEsc; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NumEsc;
      if (elig[idx]) res = {1'b1, SelW'(idx)};
    end
    return res;
  endfunction

`ifdef ESC_PING_JITTER_EN
  esc_ping_lfsr u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .jit_o (jit)
  );
`else
  assign jit = '0;
`endif

  assign {pick_vld, pick_idx} = rr_pick(en_mask_i & ~esc_active_i, ptr_q);

  assign sel_oh    = NumEsc'(1) << sel_q;
  assign w_eff     = (wait_cyc_i == '0) ? CntW'(1) : wait_cyc_i;
  assign t_eff     = (timeout_cyc_i == '0) ? CntW'(1) : timeout_cyc_i;
  assign wait_load = {1'b0, w_eff} + (CntW+1)'(jit);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter-load, pick and fail strobes.
  always_comb begin
    state_d   = state_q;
    load_wait = 1'b0;
    load_to   = 1'b0;
    take      = 1'b0;
    fail_d    = '0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = WAIT;
          load_wait = 1'b1;
        end
        WAIT: begin
          if (wcnt_q <= (CntW+1)'(1)) begin
            if (pick_vld) begin
              state_d = PING;
              load_to = 1'b1;
              take    = 1'b1;
            end else begin
              load_wait = 1'b1;
            end
          end
        end
        PING: begin
          if (ping_ok_i[sel_q]) begin
            state_d   = WAIT;
            load_wait = 1'b1;
          end else if (esc_active_i[sel_q] ||
                       !en_mask_i[sel_q]) begin
            state_d   = WAIT;
            load_wait = 1'b1;
          end else if (tcnt_q <= CntW'(1)) begin
            state_d   = WAIT;
            load_wait = 1'b1;
            fail_d    = sel_oh;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters, round-robin pointer, selection and fail pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
      tcnt_q <= '0;
      ptr_q  <= SelW'(NumEsc - 1);
      sel_q  <= '0;
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
      if (load_wait) begin
        wcnt_q <= wait_load;
      end else if (state_q == WAIT && wcnt_q != '0) begin
        wcnt_q <= wcnt_q - (CntW+1)'(1);
      end
      if (load_to) begin
        tcnt_q <= t_eff;
      end else if (state_q == PING && tcnt_q != '0) begin
        tcnt_q <= tcnt_q - CntW'(1);
      end
      if (take) begin
        ptr_q <= pick_idx;
        sel_q <= pick_idx;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy_o      = (state_q == PING);
    ping_en_o   = (state_q == PING) ? sel_oh : '0;
    ping_fail_o = fail_q;
    ping_sel_o  = sel_q;
  end

endmodule

// File: tb/tb_esc_ping_scheduler.sv
// Self-checking bench for esc_ping_scheduler.
// Transaction-level model: waits, picks and ping outcomes.
module tb_esc_ping_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  en_mask_i;
  logic [3:0]  esc_active_i;
  logic [23:0] wait_cyc_i;
  logic [23:0] timeout_cyc_i;
  logic [3:0]  ping_ok_i;
  logic [3:0]  ping_en_o;
  logic [3:0]  ping_fail_o;
  logic [1:0]  ping_sel_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int mptr;
  int cur_wait;
  int cur_to;

  esc_ping_scheduler dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .en_mask_i     (en_mask_i),
    .esc_active_i  (esc_active_i),
    .wait_cyc_i    (wait_cyc_i),
    .timeout_cyc_i (timeout_cyc_i),
    .ping_ok_i     (ping_ok_i),
    .ping_en_o     (ping_en_o),
    .ping_fail_o   (ping_fail_o),
    .ping_sel_o    (ping_sel_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef ESC_PING_JITTER_EN
  logic [15:0] m_lfsr;
  always @(posedge clk_i) begin
    if (rst_i) m_lfsr <= 16'hACE1;
    else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int wlen(input logic [23:0] w);
    int b;
    b = max1(int'(w));
`ifdef ESC_PING_JITTER_EN
    b += int'(m_lfsr[3:0]);
`endif
    return b;
  endfunction

  function automatic int next_ch(input logic [3:0] elig, input int p);
    for (int i = 1; i <= 4; i++) begin
      if (elig[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input int w, input int t);
    rst_i = 1'b1;
    en_i = 1'b0;
    ping_ok_i = '0;
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (ping_en_o !== 4'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle: en=%b busy=%b, want 0", ping_en_o, busy_o);
    end
    en_mask_i = 4'hF;
    esc_active_i = 4'h0;
    wait_cyc_i = 24'(w);
    timeout_cyc_i = 24'(t);
    cur_to = max1(t);
    mptr = 3;
    en_i = 1'b1;
    cur_wait = wlen(wait_cyc_i);
  endtask

  // Observe one WAIT period (with reloads when nothing is eligible).
  task automatic do_wait(input bit ef, input bit rnd, output int ch);
    int rounds;
    int len;
    logic [3:0] xf;
    rounds = 0;
    ch = -1;
    while (ch < 0 && rounds < 8) begin
      len = cur_wait;
      for (int c = 1; c <= len; c++) begin
        tick();
        xf = (ef && c == 1 && rounds == 0) ? 4'(1 << mptr) : 4'b0;
        checks++;
        if (ping_en_o !== 4'b0 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL wait_idle c=%0d: en=%b busy=%b, want 0",
                   c, ping_en_o, busy_o);
        end
        checks++;
        if (ping_fail_o !== xf) begin
          errors++;
          $display("FAIL wait_fail c=%0d: got %b want %b",
                   c, ping_fail_o, xf);
        end
        if (rnd && c == 1 && rounds == 0) begin
          do begin
            en_mask_i = 4'($urandom);
            esc_active_i = 4'($urandom);
          end while ((en_mask_i & ~esc_active_i) == 4'b0);
        end
        ping_ok_i = 4'($urandom);
        if (c == len) begin
          ch = next_ch(en_mask_i & ~esc_active_i, mptr);
          if (ch < 0) begin
            cur_wait = wlen(wait_cyc_i);
            rounds++;
          end
        end
      end
    end
    if (ch < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_bound: got no ping, want a pick");
    end
  endtask

  // Observe one ping; ok at cycle d, abort at cycle ab (0 = none).
  task automatic do_ping(input int ch, input int d, input int ab,
                         input int nw, input int nt, output bit fl);
    int c;
    bit done;
    logic [3:0] oh;
    oh = 4'(1 << ch);
    c = 0;
    done = 1'b0;
    fl = 1'b0;
    while (!done && c < 64) begin
      tick();
      c++;
      checks++;
      if (ping_en_o !== oh || busy_o !== 1'b1 ||
          ping_sel_o !== 2'(ch) || ping_fail_o !== 4'b0) begin
        errors++;
        $display("FAIL ping c=%0d: en=%b busy=%b sel=%0d fail=%b, want en=%b busy=1 sel=%0d fail=0000",
                 c, ping_en_o, busy_o, ping_sel_o, ping_fail_o, oh, ch);
      end
      if (c == 1) begin
        wait_cyc_i = 24'(nw);
        timeout_cyc_i = 24'(nt);
      end
      ping_ok_i = 4'($urandom) & ~oh;
      if (c == d) ping_ok_i = ping_ok_i | oh;
      if (c == ab) begin
        if ($urandom_range(0, 1) == 0) esc_active_i = esc_active_i | oh;
        else en_mask_i = en_mask_i & ~oh;
      end
      if (c == d || c == ab || c == cur_to) begin
        done = 1'b1;
        fl = (c == cur_to) && (c != d) && (c != ab);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ping_bound: got ping >64 cycles, want <=%0d", cur_to);
    end
    cur_wait = wlen(wait_cyc_i);
    mptr = ch;
    cur_to = max1(nt);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    en_i = 1'b1;
    en_mask_i = 4'hF;
    esc_active_i = 4'h0;
    wait_cyc_i = 24'd2;
    timeout_cyc_i = 24'd2;
    ping_ok_i = 4'hF;
    tick();
    tick();
    tick();
    checks++;
    if (ping_en_o !== 4'b0 || ping_fail_o !== 4'b0 ||
        ping_sel_o !== 2'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: en=%b fail=%b sel=%0d busy=%b, want all 0",
               ping_en_o, ping_fail_o, ping_sel_o, busy_o);
    end
  endtask

  task automatic test_enable;
    int ch;
    bit fl;
    start_run(5, 10);
    do_wait(1'b0, 1'b0, ch);
    do_ping(0, 2, 0, 5, 3, fl);
    do_wait(fl, 1'b0, ch);
    do_ping(1, 2, 0, 4, 3, fl);
  endtask

  task automatic test_timeout;
    int ch;
    bit fl;
    start_run(3, 3);
    do_wait(1'b0, 1'b0, ch);
    do_ping(0, 99, 0, 3, 3, fl);
    do_wait(1'b1, 1'b0, ch);
    do_ping(1, 1, 0, 3, 3, fl);
    do_wait(fl, 1'b0, ch);
  endtask

  task automatic test_skip_wrap;
    int ch;
    bit fl;
    start_run(2, 4);
    en_mask_i = 4'b1010;
    esc_active_i = 4'b0010;
    fl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_wait(fl, 1'b0, ch);
      do_ping(3, $urandom_range(1, cur_to), 0, $urandom_range(0, 3),
              4, fl);
    end
    en_mask_i = 4'b0000;
    for (int k = 0; k < 100; k++) begin
      tick();
      checks++;
      if (ping_en_o !== 4'b0 || ping_fail_o !== 4'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL mask0 k=%0d: en=%b fail=%b busy=%b, want 0",
                 k, ping_en_o, ping_fail_o, busy_o);
      end
    end
  endtask

  task automatic test_simultaneous;
    int ch;
    bit fl;
    start_run(2, 3);
    do_wait(1'b0, 1'b0, ch);
    do_ping(0, 3, 0, 2, 3, fl);
    do_wait(fl, 1'b0, ch);
    tick();
    checks++;
    if (ping_en_o !== 4'b0010) begin
      errors++;
      $display("FAIL drop_pre: got %b want 0010", ping_en_o);
    end
    en_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ping_en_o !== 4'b0 || ping_fail_o !== 4'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL drop k=%0d: en=%b fail=%b busy=%b, want 0",
                 k, ping_en_o, ping_fail_o, busy_o);
      end
    end
    mptr = 1;
    en_i = 1'b1;
    cur_wait = wlen(wait_cyc_i);
    do_wait(1'b0, 1'b0, ch);
    do_ping(2, 1, 0, 2, 3, fl);
  endtask

  task automatic test_escalation;
    int ch;
    bit fl;
    start_run(2, 6);
    do_wait(1'b0, 1'b0, ch);
    do_ping(0, 1, 0, 2, 6, fl);
    do_wait(fl, 1'b0, ch);
    do_ping(1, 1, 0, 2, 6, fl);
    do_wait(fl, 1'b0, ch);
    do_ping(2, 99, 2, 2, 6, fl);
    do_wait(fl, 1'b0, ch);
    do_ping(3, 1, 0, 2, 6, fl);
  endtask

  task automatic test_random;
    int ch;
    int d;
    int ab;
    bit fl;
    start_run(3, 3);
    fl = 1'b0;
    for (int k = 0; k < 40; k++) begin
      do_wait(fl, 1'b1, ch);
      if (ch < 0) break;
      d = $urandom_range(1, cur_to + 1);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, cur_to) : 0;
      do_ping(ch, d, ab, $urandom_range(0, 6), $urandom_range(0, 5), fl);
    end
  endtask

`ifdef ESC_PING_JITTER_EN
  task automatic test_jitter;
    int n;
    int expw;
    int distinct;
    bit seen [17];
    for (int i = 0; i < 17; i++) seen[i] = 1'b0;
    start_run(1, 4);
    expw = cur_wait;
    for (int k = 0; k < 64; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (ping_en_o == 4'b0 && n < 40);
      n = n - 1;
      checks++;
      if (n !== expw || n < 1 || n > 16) begin
        errors++;
        $display("FAIL jitter_len k=%0d: got %0d want %0d", k, n, expw);
      end
      if (n >= 0 && n <= 16) seen[n] = 1'b1;
      ping_ok_i = ping_en_o;
      expw = wlen(wait_cyc_i);
    end
    distinct = 0;
    for (int i = 0; i < 17; i++) if (seen[i]) distinct++;
    checks++;
    if (distinct < 8) begin
      errors++;
      $display("FAIL jitter_distinct: got %0d want >=8", distinct);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_enable();
    test_timeout();
    test_skip_wrap();
    test_simultaneous();
    test_escalation();
    test_random();
`ifdef ESC_PING_JITTER_EN
    test_jitter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
